circuit: RTL and testbench

CIRCUIT -- requirements
Module: circuit

---
 rtl/circuit.sv | 95 +++++++++
 tb/tb_circuit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/circuit.sv
// ---------------------------------------------------------------------------
// circuit -- gated two-phase oscillator
//
// Purpose:
//   When the enable A is sampled high, the output y toggles every clock. The
//   first high cycle after A rises is always y=1. When A is sampled low, y
//   returns to 0 on that edge. A later rise of A starts a new oscillation at
//   y=1; it does not continue the old phase.
//
//   The design is a three-state Moore machine: IDLE, HIGH and LOW. y comes
//   from its own flop, so it never changes combinationally with A.
//
// Ports:
//   clk  in   1  single clock; all state changes on its rising edge
//   rst  in   1  synchronous, active-high reset; takes priority over A
//   A    in   1  oscillation enable, level-sensitive
//   y    out  1  registered oscillator output
//
// Configuration:
//   CIRCUIT_SYNC_IN_EN  When defined, a 2-flop synchronizer is placed in front
//                       of the FSM on A. A-to-y latency becomes 3 clocks.
//                       When undefined (the default), A drives the FSM
//                       directly with 1-clock latency.
// ---------------------------------------------------------------------------
module circuit (
    input  logic clk,
    input  logic rst,
    input  logic A,
    output logic y
);

    // State codes are fixed at 2 bits. Code 2'b11 is unused and recovers to IDLE.
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] HIGH = 2'b01;
    localparam logic [1:0] LOW  = 2'b10;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       next_y;
    logic       a_fsm;

`ifdef CIRCUIT_SYNC_IN_EN
    logic a_sync1;
    logic a_sync2;

    // Two-stage synchronizer on the enable. Both stages clear on reset so
    // that a stale high cannot restart the oscillator after reset releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sync1 <= 1'b0;
            a_sync2 <= 1'b0;
        end else begin
            a_sync1 <= A;
            a_sync2 <= a_sync1;
        end
    end

    assign a_fsm = a_sync2;
`else
    assign a_fsm = A;
`endif

    // Next-state logic. A low enable always returns to IDLE, whatever the
    // current state. A high enable moves HIGH to LOW. From IDLE or LOW, a
    // high enable moves to HIGH. Because IDLE goes to HIGH, a restart always
    // begins on a high cycle. The unused code falls into the default arm and
    // recovers to IDLE.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = a_fsm ? HIGH : IDLE;
            HIGH:    next_state = a_fsm ? LOW  : IDLE;
            LOW:     next_state = a_fsm ? HIGH : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // y is the Moore decode of the state being entered. It is registered in
    // parallel with the state, so the output comes straight from a flop.
    always_comb begin
        next_y = (next_state == HIGH);
    end

    // State and output registers. Reset wins over the enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            y     <= 1'b0;
        end else begin
            state <= next_state;
            y     <= next_y;
        end
    end

endmodule

// File: tb/tb_circuit.sv
// ---------------------------------------------------------------------------
// tb_circuit -- self-checking bench for the gated oscillator
//
// Phases:
//   1. A table of {rst, A, expected y} vectors applied one per clock
//      (default build only).
//   2. Hand-written multi-cycle sequences: a one-cycle pulse, A changing
//      between edges, and the synchronizer latency in the sync build.
//   3. Randomized rst/A compared against a behavioural model. The model
//      counts consecutive sampled-high enables; y is high on odd counts.
// ---------------------------------------------------------------------------
module tb_circuit;

    logic clk;
    logic rst;
    logic A;
    logic y;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic rst;
        logic a;
        logic expy;
    } vec_t;

    circuit dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .y   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the inputs away from the rising edge, then step past that edge.
    task automatic applyStimulus(input logic r, input logic a);
        @(negedge clk);
        rst = r;
        A   = a;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic expy);
        checks++;
        if (y !== expy) begin
            errors++;
            $display("[TB] FAIL %s: y=%b expected=%b at %0t", name, y, expy, $time);
        end
    endtask

    // Behavioural model. The model tracks the run of sampled-high enables.
    // In the sync build, the enable reaches the FSM two edges late.
    int   run_len = 0;
    logic d1 = 1'b0;
    logic d2 = 1'b0;

    function automatic logic modelStep(input logic r, input logic a);
        logic seen;
`ifdef CIRCUIT_SYNC_IN_EN
        seen = d2;
        d2   = d1;
        d1   = a;
`else
        seen = a;
`endif
        if (r) begin
            run_len = 0;
            d1 = 1'b0;
            d2 = 1'b0;
            return 1'b0;
        end
        run_len = seen ? run_len + 1 : 0;
        return run_len[0];
    endfunction

    initial begin
        vec_t vecs[$];
        logic r;
        logic a;
        logic e;

        rst = 1'b1;
        A   = 1'b0;

`ifndef CIRCUIT_SYNC_IN_EN
        // Reset with A high: y stays 0 on both edges.
        vecs.push_back('{1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0});

        // Enable held high: y = 1,0,1,0,1,0.
        vecs.push_back('{1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b0});

        // Drop: A=0 once, A=1 for three edges, then A=0 held.
        vecs.push_back('{1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0});

        // Restart: A = 1,1,0,1,1 gives y = 1,0,0,1,0.
        vecs.push_back('{1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b0});

        // Mid-run reset on the 4th edge with A high, then release.
        vecs.push_back('{1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b0});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].a);
            checkOutput($sformatf("vec%0d", i), vecs[i].expy);
        end

        // One-cycle pulse from IDLE: exactly one high cycle.
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("pulse_high", 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("pulse_low0", 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("pulse_low1", 1'b0);

        // A high only between edges must not be seen.
        @(negedge clk);
        A = 1'b0;
        #2 A = 1'b1;
        #2 A = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("between_edges", 1'b0);
`else
        // Sync build: clear everything, then step A to 1 before edge k.
        // The first y=1 is expected after edge k+2.
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("sync_reset", 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("sync_k", 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("sync_k1", 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("sync_k2", 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("sync_k3", 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("sync_k4", 1'b1);
`endif

        // Randomized phase. It starts with a forced reset so the model and
        // the DUT begin from the same state.
        void'(modelStep(1'b1, 1'b0));
        applyStimulus(1'b1, 1'b0);
        checkOutput("rand_reset", 1'b0);
        for (int i = 0; i < 500; i++) begin
            r = ($urandom_range(0, 99) < 4);
            a = ($urandom_range(0, 99) < 75);
            e = modelStep(r, a);
            applyStimulus(r, a);
            checkOutput($sformatf("rand%0d", i), e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
